// File: rtl/mvu_job_scheduler_pkg.sv
// Shared types and default sizing for the MVU job scheduler slice.
package mvu_job_scheduler_pkg;

    localparam int DEF_NMVU       = 8;
    localparam int DEF_DESC_W     = 64;
    localparam int DEF_ID_W       = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // Lifecycle of one MVU slot: free, running a job, or holding an undelivered completion.
    typedef enum logic [1:0] {
        MVU_IDLE = 2'd0,
        MVU_RUN  = 2'd1,
        MVU_PEND = 2'd2
    } mvu_state_t;

    // One queued job as pito hands it over; the descriptor is opaque to the scheduler.
    typedef struct packed {
        logic [DEF_DESC_W-1:0] desc;
        logic [DEF_ID_W-1:0]   id;
    } job_t;

endpackage

// File: rtl/mvu_job_scheduler_if.sv
// Bundle of the pito job port, the MVU start/done lines and the completion port.
// master = pito / MVU array side, slave = scheduler side.
interface mvu_job_scheduler_if
    import mvu_job_scheduler_pkg::*;
#(
    parameter int NMVU       = DEF_NMVU,
    parameter int DESC_W     = DEF_DESC_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int IDX_W = $clog2(NMVU);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              job_valid;
    logic              job_ready;
    logic [DESC_W-1:0] job_desc;
    logic [ID_W-1:0]   job_id;

    logic [NMVU-1:0]   mvu_start;
    logic [DESC_W-1:0] mvu_desc;
    logic [NMVU-1:0]   mvu_done;

    logic              cmpl_valid;
    logic              cmpl_ready;
    logic [ID_W-1:0]   cmpl_id;
    logic [IDX_W-1:0]  cmpl_mvu;

    logic [CNT_W-1:0]  q_count;
    logic              busy;
    logic              err_spur;

    modport master (
        output job_valid, job_desc, job_id, mvu_done, cmpl_ready,
        input  job_ready, mvu_start, mvu_desc, cmpl_valid, cmpl_id, cmpl_mvu,
               q_count, busy, err_spur
    );

    modport slave (
        input  job_valid, job_desc, job_id, mvu_done, cmpl_ready,
        output job_ready, mvu_start, mvu_desc, cmpl_valid, cmpl_id, cmpl_mvu,
               q_count, busy, err_spur
    );

endinterface

// File: rtl/mvu_job_scheduler_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Storage array; contents need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mvu_job_scheduler.sv
// Queues pito job descriptors and issues them round-robin to idle MVUs, then hands
// each MVU's completion back to pito before the MVU may take another job.
module mvu_job_scheduler
    import mvu_job_scheduler_pkg::*;
#(
    parameter int NMVU       = DEF_NMVU,
    parameter int DESC_W     = DEF_DESC_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mvu_job_scheduler_if.slave    bus
);
    localparam int IDX_W  = $clog2(NMVU);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = DESC_W + ID_W;

    mvu_state_t        mvuState_q [NMVU];
    mvu_state_t        mvuState_d [NMVU];
    logic [ID_W-1:0]   idTbl_q    [NMVU];
    logic [ID_W-1:0]   idTbl_d    [NMVU];
    logic [IDX_W-1:0]  rrPtr_q,    rrPtr_d;
    logic [IDX_W-1:0]  cmplPtr_q,  cmplPtr_d;
    logic [NMVU-1:0]   mvuStart_q, mvuStart_d;
    logic [DESC_W-1:0] mvuDesc_q,  mvuDesc_d;
    logic              errSpur_q,  errSpur_d;

    logic [NMVU-1:0]   idleMask;
    logic [NMVU-1:0]   runMask;
    logic [NMVU-1:0]   pendMask;
    logic [WORD_W-1:0] headWord;
    logic [CNT_W-1:0]  fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pushEn;
    logic              popEn;
    logic              dispatchGo;
    logic [IDX_W-1:0]  grantIdx;
    logic [IDX_W-1:0]  cmplSel;

    // First set bit of mask at or after ptr, wrapping; returns ptr when mask is empty.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NMVU-1:0] mask,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NMVU - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NMVU) begin
                idx = idx - NMVU;
            end
            if (mask[idx]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
        return (int'(i) == NMVU - 1) ? '0 : i + 1'b1;
    endfunction

    assign pushEn = bus.job_valid && !fifoFull;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushEn),
        .wdata_i ({bus.job_desc, bus.job_id}),
        .pop_i   (popEn),
        .rdata_o (headWord),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Decode the per-MVU state table into eligibility, running and pending masks.
    always_comb begin
        idleMask = '0;
        runMask  = '0;
        pendMask = '0;
        for (int i = 0; i < NMVU; i++) begin
            idleMask[i] = (mvuState_q[i] == MVU_IDLE);
            runMask[i]  = (mvuState_q[i] == MVU_RUN);
            pendMask[i] = (mvuState_q[i] == MVU_PEND);
        end
    end

    assign dispatchGo = !fifoEmpty && (|idleMask);
    assign grantIdx   = rr_pick(idleMask, rrPtr_q);
    assign cmplSel    = rr_pick(pendMask, cmplPtr_q);

    // Next state: one dispatch per cycle, done pulses move RUN to PEND, a completion
    // handshake frees the presented MVU. While a record waits, the completion pointer
    // parks on it so newly pending MVUs cannot displace the presented record.
    always_comb begin
        mvuState_d = mvuState_q;
        idTbl_d    = idTbl_q;
        rrPtr_d    = rrPtr_q;
        cmplPtr_d  = cmplPtr_q;
        mvuStart_d = '0;
        mvuDesc_d  = '0;
        errSpur_d  = errSpur_q;
        popEn      = 1'b0;

        if (dispatchGo) begin
            popEn                = 1'b1;
            mvuStart_d[grantIdx] = 1'b1;
            mvuDesc_d            = headWord[WORD_W-1:ID_W];
            idTbl_d[grantIdx]    = headWord[ID_W-1:0];
            mvuState_d[grantIdx] = MVU_RUN;
            rrPtr_d              = rr_next(grantIdx);
        end

        for (int i = 0; i < NMVU; i++) begin
            if (bus.mvu_done[i]) begin
                if (mvuState_q[i] == MVU_RUN) begin
                    mvuState_d[i] = MVU_PEND;
                end else begin
                    errSpur_d = 1'b1;
                end
            end
        end

        if (|pendMask) begin
            if (bus.cmpl_ready) begin
                mvuState_d[cmplSel] = MVU_IDLE;
                cmplPtr_d           = rr_next(cmplSel);
            end else begin
                cmplPtr_d           = cmplSel;
            end
        end
    end

    // State register with synchronous active-low reset dropping all in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NMVU; i++) begin
                mvuState_q[i] <= MVU_IDLE;
                idTbl_q[i]    <= '0;
            end
            rrPtr_q    <= '0;
            cmplPtr_q  <= '0;
            mvuStart_q <= '0;
            mvuDesc_q  <= '0;
            errSpur_q  <= 1'b0;
        end else begin
            mvuState_q <= mvuState_d;
            idTbl_q    <= idTbl_d;
            rrPtr_q    <= rrPtr_d;
            cmplPtr_q  <= cmplPtr_d;
            mvuStart_q <= mvuStart_d;
            mvuDesc_q  <= mvuDesc_d;
            errSpur_q  <= errSpur_d;
        end
    end

    assign bus.job_ready  = !fifoFull;
    assign bus.mvu_start  = mvuStart_q;
    assign bus.mvu_desc   = mvuDesc_q;
    assign bus.cmpl_valid = |pendMask;
    assign bus.cmpl_id    = idTbl_q[cmplSel];
    assign bus.cmpl_mvu   = cmplSel;
    assign bus.q_count    = fifoCount;
    assign bus.busy       = (fifoCount != '0) || (|runMask) || (|pendMask);
    assign bus.err_spur   = errSpur_q;

endmodule
